// File: rtl/ads127l1x_tdm_deser_v2.sv
// ADS127L1x TDM data-port deserializer. Synchronises the ADC pins, frames on the
// FSYNC rising edge and delivers one packed channel word per frame with error/lock status.
//
// state   | meaning
// S_IDLE  | waiting for the first SOF after reset or while en was low
// S_SHIFT | capturing frame bits, cnt_q = bits taken so far
// S_WAIT  | frame delivered, DOUT ignored until the next SOF
module ads127l1x_tdm_deser_v2 #(
    parameter int CHANNEL_COUNT   = 8,
    parameter int LANE_COUNT      = 4,
    parameter int BITS_PER_PACKET = 24,
    parameter int DCLK_EDGE       = 1,
    parameter int LOCK_FRAMES     = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic                                     adc_fsync,
    input  logic                                     adc_dclk,
    input  logic [LANE_COUNT-1:0]                    adc_dout,
    output logic [CHANNEL_COUNT*BITS_PER_PACKET-1:0] ch_data,
    output logic                                     data_valid,
    output logic [15:0]                              frame_seq,
    output logic                                     frame_err,
    output logic [7:0]                               err_count,
    output logic                                     lock
);

    localparam int CPL = CHANNEL_COUNT / LANE_COUNT;
    localparam int N   = CPL * BITS_PER_PACKET;
    localparam int W   = CHANNEL_COUNT * BITS_PER_PACKET;
    localparam logic [8:0] LAST_BIT = 9'(N - 1);
    localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

    state_t                      state_q, state_d;
    logic [1:0]                  fsync_sync;
    logic [2:0]                  dclk_sync;
    logic [LANE_COUNT-1:0]       dout_s1, dout_s2;
    logic                        fsync_hist;
    logic                        strobe, sof;
    logic [LANE_COUNT*N-1:0]     shift_q, shift_next;
    logic [W-1:0]                frame_map;
    logic [8:0]                  cnt_q;
    logic [3:0]                  run_q;
    logic                        done_q;
    logic                        shift_en, cnt_start, cnt_step, frame_done, short_err;

    // Synchronisers are free-running; FSYNC and DOUT come from the stage that feeds the edge detector.
    always_ff @(posedge clk) begin
        fsync_sync <= {fsync_sync[0], adc_fsync};
        dclk_sync  <= {dclk_sync[1:0], adc_dclk};
        dout_s1    <= adc_dout;
        dout_s2    <= dout_s1;
    end

    assign strobe = (DCLK_EDGE != 0) ? (dclk_sync[1] & ~dclk_sync[2])
                                     : (~dclk_sync[1] & dclk_sync[2]);
    assign sof    = strobe & fsync_sync[1] & ~fsync_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_WAIT: if (sof) state_d = S_SHIFT;
            S_SHIFT:        if (strobe && !sof && cnt_q == LAST_BIT) state_d = S_WAIT;
            default:        state_d = S_IDLE;
        endcase
        if (!en) state_d = S_IDLE;
    end

    always_comb begin
        shift_en   = 1'b0;
        cnt_start  = 1'b0;
        cnt_step   = 1'b0;
        frame_done = 1'b0;
        short_err  = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE, S_WAIT: begin
                    if (sof) begin
                        shift_en  = 1'b1;
                        cnt_start = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (strobe) begin
                        shift_en = 1'b1;
                        if (sof) begin
                            cnt_start = 1'b1;
                            short_err = 1'b1;
                        end else begin
                            cnt_step   = 1'b1;
                            frame_done = (cnt_q == LAST_BIT);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_next = shift_q;
        for (int l = 0; l < LANE_COUNT; l++) begin
            shift_next[l*N +: N] = {shift_q[l*N +: N-1], dout_s2[l]};
        end
    end

    // First channel of a lane ends up in the top packet of that lane's register.
    always_comb begin
        frame_map = '0;
        for (int l = 0; l < LANE_COUNT; l++) begin
            for (int k = 0; k < CPL; k++) begin
                frame_map[(l*CPL + k)*BITS_PER_PACKET +: BITS_PER_PACKET] =
                    shift_q[l*N + (CPL-1-k)*BITS_PER_PACKET +: BITS_PER_PACKET];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsync_hist <= 1'b1;
            shift_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ch_data    <= '0;
            data_valid <= 1'b0;
            frame_seq  <= '0;
            frame_err  <= 1'b0;
            err_count  <= '0;
            run_q      <= '0;
            lock       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            done_q     <= frame_done;
            if (strobe) fsync_hist <= fsync_sync[1];
            if (shift_en) shift_q <= shift_next;
            if (cnt_start) begin
                cnt_q <= 9'd1;
            end else if (cnt_step) begin
                cnt_q <= cnt_q + 9'd1;
            end
            if (done_q && en) begin
                ch_data    <= frame_map;
                data_valid <= 1'b1;
                frame_seq  <= frame_seq + 16'd1;
                if (run_q != LOCK_N) run_q <= run_q + 4'd1;
                if (run_q >= LOCK_N - 4'd1) lock <= 1'b1;
            end
            if (short_err) begin
                frame_err <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                run_q <= '0;
                lock  <= 1'b0;
            end
            if (!en) begin
                run_q <= '0;
                lock  <= 1'b0;
            end
        end
    end

endmodule
